// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: sequential word fetch, {pc, inst} prefetch FIFO, redirect flush.
// Latency: a response accepted at edge t is visible on out_valid in cycle t+1 (no bypass).
// Backpressure: requests stop while FIFO occupancy + outstanding requests reach DEPTH; out_ready low holds the head.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   imem_req_valid/ready/addr       fetch request channel (word-aligned address)
//   imem_rsp_valid/data             in-order, unstallable response channel
//   redirect_valid/pc               flush and restart fetch at redirect_pc (low two bits ignored)
//   out_valid/ready/inst/pc         FIFO head towards the decoder
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  logic [31:0]   fetch_pc;
  entry_t        fifo_mem [DEPTH];
  logic [AW-1:0] fifo_rd_ptr;
  logic [AW-1:0] fifo_wr_ptr;
  logic [31:0]   pc_q [DEPTH];
  logic [AW-1:0] pcq_rd_ptr;
  logic [AW-1:0] pcq_wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;

  logic          req_fire;
  logic          rsp_keep;
  logic          pop;
  logic [CW:0]   credits_used;
  logic [CW-1:0] req_inc;
  logic [CW-1:0] rsp_dec;
  logic [CW-1:0] push_inc;
  logic [CW-1:0] pop_dec;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Every FIFO slot is pre-reserved at request time, so a kept response always has room.
  assign credits_used   = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = !rst && !redirect_valid && (credits_used < DEPTH_W);
  assign imem_req_addr  = rst ? RESET_PC : fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Redirect discards the same-cycle response and overrides any same-cycle pop.
  assign rsp_keep  = imem_rsp_valid && (drop == '0) && !redirect_valid;
  assign out_valid = !rst && (count != '0);
  assign pop       = out_valid && out_ready && !redirect_valid;
  assign out_inst  = rst ? 32'h0 : fifo_mem[fifo_rd_ptr].inst;
  assign out_pc    = rst ? 32'h0 : fifo_mem[fifo_rd_ptr].pc;

  assign req_inc  = {{(CW-1){1'b0}}, req_fire};
  assign rsp_dec  = {{(CW-1){1'b0}}, imem_rsp_valid};
  assign push_inc = {{(CW-1){1'b0}}, rsp_keep};
  assign pop_dec  = {{(CW-1){1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      fifo_rd_ptr <= '0;
      fifo_wr_ptr <= '0;
      pcq_rd_ptr  <= '0;
      pcq_wr_ptr  <= '0;
    end else begin
      outstanding <= outstanding + req_inc - rsp_dec;
      // The pc shadow queue tracks in-flight requests, so it is never flushed by a redirect.
      if (req_fire)       pcq_wr_ptr <= pcq_wr_ptr + PTR_ONE;
      if (imem_rsp_valid) pcq_rd_ptr <= pcq_rd_ptr + PTR_ONE;

      if (redirect_valid) begin
        fetch_pc    <= {redirect_pc[31:2], 2'b00};
        count       <= '0;
        fifo_rd_ptr <= fifo_wr_ptr;
        // Everything still in flight after this cycle's response belongs to the old path.
        drop        <= outstanding - rsp_dec;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (imem_rsp_valid && (drop != '0)) drop <= drop - CNT_ONE;
        if (rsp_keep) fifo_wr_ptr <= fifo_wr_ptr + PTR_ONE;
        if (pop)      fifo_rd_ptr <= fifo_rd_ptr + PTR_ONE;
        count <= count + push_inc - pop_dec;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) pc_q[pcq_wr_ptr] <= fetch_pc;
  end

  always_ff @(posedge clk) begin
    if (!rst && rsp_keep) fifo_mem[fifo_wr_ptr] <= '{pc: pc_q[pcq_rd_ptr], inst: imem_rsp_data};
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    rsp_keep |-> ({1'b0, count} < DEPTH_W));
  a_rsp_has_req: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Memory contents: a fixed hash of the address, so a mispaired pc/inst is visible.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: after reset/redirect to T, the decoder must see T, T+4, T+8, ...
  // with inst_of(pc), and the memory must be asked for the same sequence.
  logic [31:0] exp_q[$];
  logic [31:0] exp_tail;
  logic [31:0] req_exp;

  task automatic flush_expect(input logic [31:0] tgt);
    exp_q.delete();
    exp_tail = {tgt[31:2], 2'b00};
    req_exp  = exp_tail;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(exp_tail);
      exp_tail += 32'd4;
    end
  endtask

  // ---------------- memory model ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];
  int cyc = 0;
  int lat_min = 1;
  int lat_max = 1;
  int rdy_pct = 100;
  bit rdy_hold_low = 1'b0;

  initial begin : mem
    bit          hs;
    bit          rf;
    bit          in_rst;
    logic [31:0] ha;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      hs     = imem_req_valid && imem_req_ready;
      ha     = imem_req_addr;
      rf     = imem_rsp_valid;
      in_rst = rst;
      @(posedge clk);
      #2;
      cyc++;
      if (in_rst) mq.delete();
      else begin
        if (rf && mq.size() > 0) void'(mq.pop_front());
        if (hs) mq.push_back('{addr: ha, due: cyc + int'($urandom_range(lat_min, lat_max)) - 1});
      end
      imem_rsp_valid = !in_rst && (mq.size() > 0) && (mq[0].due <= cyc);
      imem_rsp_data  = imem_rsp_valid ? inst_of(mq[0].addr) : $urandom;
      imem_req_ready = !rdy_hold_low && (int'($urandom_range(0, 99)) < rdy_pct);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int pop_cnt = 0;
  int hs_cnt = 0;
  int stall = 0;

  initial begin : mon
    bit          prev_wait;
    logic [31:0] prev_addr;
    logic [31:0] e;
    prev_wait = 1'b0;
    prev_addr = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check1("rst_out_valid", out_valid, 1'b0);
        check1("rst_req_valid", imem_req_valid, 1'b0);
        check32("rst_out_pc", out_pc, 32'h0);
        check32("rst_out_inst", out_inst, 32'h0);
        check32("rst_req_addr", imem_req_addr, RESET_PC);
        prev_wait = 1'b0;
        stall = 0;
      end else begin
        if (redirect_valid) check1("redir_req_valid", imem_req_valid, 1'b0);
        else if (prev_wait) begin
          check1("req_hold_valid", imem_req_valid, 1'b1);
          check32("req_hold_addr", imem_req_addr, prev_addr);
        end
        if (imem_req_valid && imem_req_ready) begin
          check32("req_addr", imem_req_addr, req_exp);
          req_exp += 32'd4;
          hs_cnt++;
        end
        if (out_valid && out_ready && !redirect_valid) begin
          while (exp_q.size() < 8) begin
            exp_q.push_back(exp_tail);
            exp_tail += 32'd4;
          end
          e = exp_q.pop_front();
          check32("out_pc", out_pc, e);
          check32("out_inst", out_inst, inst_of(e));
          pop_cnt++;
          stall = 0;
        end else if (out_ready && !redirect_valid && !out_valid) begin
          stall++;
          if (stall > 40) begin
            checks++;
            errors++;
            $display("FAIL progress: no instruction for %0d cycles with out_ready high, required <= 40", stall);
            stall = 0;
          end
        end
        if (redirect_valid) stall = 0;
        prev_wait = imem_req_valid && !imem_req_ready;
        prev_addr = imem_req_addr;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    redirect_valid = 1'b0;
    flush_expect(RESET_PC);
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    flush_expect(t);
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin : drv
    int p0;
    int h0;
    int n;
    int r;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    out_ready = 1'b0;
    flush_expect(RESET_PC);

    // 1: reset release, 1-cycle memory, decoder always ready
    out_ready = 1'b1;
    do_reset(3);
    @(negedge clk);
    check1("t1_first_req_valid", imem_req_valid, 1'b1);
    check32("t1_first_req_addr", imem_req_addr, RESET_PC);
    check1("t1_out_valid_c0", out_valid, 1'b0);
    @(negedge clk);
    check1("t1_out_valid_c1", out_valid, 1'b0);
    @(negedge clk);
    check1("t1_out_valid_c2", out_valid, 1'b1);
    check32("t1_first_out_pc", out_pc, RESET_PC);
    #1;
    p0 = pop_cnt;
    repeat (12) @(negedge clk);
    #1;
    check32("t1_throughput", pop_cnt - p0, 32'd12);

    // 2: decoder stalled -> exactly DEPTH requests, then one pop frees one credit
    tick();
    out_ready = 1'b0;
    h0 = hs_cnt;
    do_reset(2);
    repeat (12) tick();
    check32("t2_req_count", hs_cnt - h0, DEPTH);
    @(negedge clk);
    check1("t2_req_valid_full", imem_req_valid, 1'b0);
    check1("t2_out_valid_full", out_valid, 1'b1);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    check1("t2_req_after_pop", imem_req_valid, 1'b1);
    check32("t2_addr_after_pop", imem_req_addr, 32'h10);

    // 3: memory not ready for 3 cycles while the request for 0x8 is pending
    tick();
    out_ready = 1'b1;
    do_reset(2);
    tick();
    tick();
    rdy_hold_low = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check1("t3_hold_valid", imem_req_valid, 1'b1);
      check32("t3_hold_addr", imem_req_addr, 32'h8);
    end
    tick();
    rdy_hold_low = 1'b0;
    repeat (8) tick();

    // 4: 3-cycle memory, redirect with two requests in flight
    lat_min = 3;
    lat_max = 3;
    do_reset(2);
    tick();
    tick();
    redirect(32'h0000_0103);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check1("t4_out_valid", out_valid, 1'b1);
    check32("t4_first_pc", out_pc, 32'h100);
    check32("t4_first_inst", out_inst, inst_of(32'h100));
    tick();
    repeat (10) tick();

    // 5: redirect coinciding with a response and a ready decoder
    lat_min = 1;
    lat_max = 1;
    do_reset(2);
    repeat (6) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    flush_expect(32'h0000_0200);
    @(negedge clk);
    check1("t5_out_valid_pre", out_valid, 1'b1);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check1("t5_fifo_empty", out_valid, 1'b0);
    check1("t5_req_valid", imem_req_valid, 1'b1);
    check32("t5_req_addr", imem_req_addr, 32'h200);
    tick();
    repeat (8) tick();

    // 6: reset while the FIFO is full
    out_ready = 1'b0;
    do_reset(2);
    repeat (10) tick();
    @(negedge clk);
    check1("t6_full_valid", out_valid, 1'b1);
    tick();
    do_reset(1);
    @(negedge clk);
    check1("t6_out_valid_after_rst", out_valid, 1'b0);
    check1("t6_req_valid_after_rst", imem_req_valid, 1'b1);
    check32("t6_req_addr_after_rst", imem_req_addr, RESET_PC);
    tick();

    // 7: fetch address wrap
    out_ready = 1'b1;
    redirect(32'hFFFF_FFF4);
    p0 = pop_cnt;
    repeat (12) tick();
    check1("t7_wrap_progress", (pop_cnt - p0) >= 6, 1'b1);

    // 8: randomized traffic
    lat_min = 1;
    lat_max = 3;
    rdy_pct = 70;
    p0 = pop_cnt;
    for (int i = 0; i < 3000; i++) begin
      out_ready = (int'($urandom_range(0, 99)) < 75);
      r = int'($urandom_range(0, 999));
      if (r < 5) begin
        rst = 1'b1;
        redirect_valid = 1'b0;
        flush_expect(RESET_PC);
      end else if (r < 60) begin
        rst = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = $urandom;
        flush_expect(redirect_pc);
      end else begin
        rst = 1'b0;
        redirect_valid = 1'b0;
      end
      tick();
    end
    rst = 1'b0;
    redirect_valid = 1'b0;
    repeat (10) tick();
    check1("t8_random_progress", (pop_cnt - p0) >= 500, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
